// File: rtl/req_encoder_if.sv
// Request/offer bundle for req_encoder: request inputs, valid/ready index offer, pending status.
// master = encoder side, slave = requester/consumer side.
interface req_encoder_if #(
    parameter int N = 8,
    parameter int W = 3
);
    logic         e;
    logic [N-1:0] req;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic [N-1:0] pending;
    logic         any;

    modport master (
        input  e,
        input  req,
        input  out_ready,
        output out_valid,
        output out_idx,
        output pending,
        output any
    );

    modport slave (
        output e,
        output req,
        output out_ready,
        input  out_valid,
        input  out_idx,
        input  pending,
        input  any
    );
endinterface

// File: rtl/req_encoder.sv
// Sticky-pending N-to-log2(N) priority encoder offering one index at a time over valid/ready.
// Define REQ_ENCODER_RR_EN for round-robin priority; default is fixed lowest-index-wins.
module req_encoder #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    req_encoder_if.master bus
);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t       r_state;
    state_t       w_nextState;
    logic [N-1:0] r_pending;
    logic [W-1:0] r_idx;
    logic [W-1:0] w_nextIdx;
    logic         w_fire;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_masked;
    logic         w_hasCand;
    logic [W-1:0] w_cand;

    assign w_fire    = (r_state == OFFER) && bus.out_ready;
    assign w_clr     = w_fire ? (N'(1) << r_idx) : '0;
    assign w_masked  = r_pending & ~w_clr;
    assign w_hasCand = |w_masked;

`ifdef REQ_ENCODER_RR_EN
    logic [W-1:0] r_last;
    logic [W-1:0] w_base;

    // Search starts just past the most recent grant; on a fire edge that grant is out_idx itself.
    assign w_base = w_fire ? r_idx : r_last;

    always_comb begin
        logic [W-1:0] probe;
        probe  = '0;
        w_cand = '0;
        for (int i = N; i >= 1; i--) begin
            probe = w_base + W'(i);
            if (w_masked[probe]) begin
                w_cand = probe;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= W'(N - 1);
        end else if (w_fire) begin
            r_last <= r_idx;
        end
    end
`else
    always_comb begin
        w_cand = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                w_cand = W'(i);
            end
        end
    end
`endif

    always_comb begin
        w_nextState = r_state;
        w_nextIdx   = r_idx;
        case (r_state)
            IDLE: begin
                if (bus.e && w_hasCand) begin
                    w_nextIdx   = w_cand;
                    w_nextState = OFFER;
                end
            end
            OFFER: begin
                // Enable only gates new offers; a live offer is held until it is accepted.
                if (w_fire) begin
                    if (bus.e && w_hasCand) begin
                        w_nextIdx = w_cand;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_pending <= '0;
        end else begin
            r_state   <= w_nextState;
            r_idx     <= w_nextIdx;
            r_pending <= w_masked | bus.req;
        end
    end

    assign bus.out_valid = (r_state == OFFER);
    assign bus.out_idx   = r_idx;
    assign bus.pending   = r_pending;
    assign bus.any       = |r_pending;

endmodule

// File: tb/tb_req_encoder.sv
// Scoreboard bench for req_encoder: directed stimulus pushes expected grants, a monitor pops them on each fire.
module tb_req_encoder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [2:0] expQ[$];

    req_encoder_if #(.N(8), .W(3)) bus ();

    req_encoder #(.N(8), .W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [7:0] rq, input logic rdy);
        bus.e         = en;
        bus.req       = rq;
        bus.out_ready = rdy;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Each negedge with valid&ready precedes exactly one fire edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL grant_unexpected: got %0d expected none", bus.out_idx);
            end else begin
                checkOutput("grant_idx", int'(bus.out_idx), int'(expQ.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick();
        checkOutput("rst_valid", int'(bus.out_valid), 0);
        checkOutput("rst_pending", int'(bus.pending), 'h00);
        checkOutput("rst_any", int'(bus.any), 0);
        checkOutput("rst_idx", int'(bus.out_idx), 0);

        // Two requests served back to back, lowest first.
        applyStimulus(1'b1, 8'h24, 1'b0);
        tick();
        applyStimulus(1'b1, 8'h00, 1'b0);
        checkOutput("p24_pending", int'(bus.pending), 'h24);
        checkOutput("p24_nooffer", int'(bus.out_valid), 0);
        expQ.push_back(3'd2);
        expQ.push_back(3'd5);
        applyStimulus(1'b1, 8'h00, 1'b1);
        tick();
        checkOutput("p24_valid", int'(bus.out_valid), 1);
        checkOutput("p24_idx2", int'(bus.out_idx), 2);
        tick();
        checkOutput("p24_nobubble", int'(bus.out_valid), 1);
        checkOutput("p24_idx5", int'(bus.out_idx), 5);
        tick();
        applyStimulus(1'b1, 8'h00, 1'b0);
        checkOutput("p24_idle", int'(bus.out_valid), 0);
        checkOutput("p24_empty", int'(bus.pending), 'h00);
        checkOutput("p24_any", int'(bus.any), 0);

        // Held offer of 3 while a lower request arrives with enable low.
        applyStimulus(1'b1, 8'h08, 1'b0);
        tick();
        applyStimulus(1'b1, 8'h00, 1'b0);
        tick();
        checkOutput("hold_idx3", int'(bus.out_idx), 3);
        applyStimulus(1'b0, 8'h02, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        tick();
        checkOutput("hold_valid_e0", int'(bus.out_valid), 1);
        checkOutput("hold_idx_stable", int'(bus.out_idx), 3);
        checkOutput("hold_pending", int'(bus.pending), 'h0A);
        expQ.push_back(3'd3);
        expQ.push_back(3'd1);
        applyStimulus(1'b1, 8'h00, 1'b1);
        tick();
        checkOutput("hold_next_idx1", int'(bus.out_idx), 1);
        tick();
        applyStimulus(1'b1, 8'h00, 1'b0);
        checkOutput("hold_idle", int'(bus.out_valid), 0);

        // Request for 4 in its own fire cycle: set wins, re-offered after a gap.
        applyStimulus(1'b1, 8'h10, 1'b0);
        tick();
        applyStimulus(1'b1, 8'h00, 1'b0);
        tick();
        expQ.push_back(3'd4);
        expQ.push_back(3'd4);
        applyStimulus(1'b1, 8'h10, 1'b1);
        tick();
        applyStimulus(1'b1, 8'h00, 1'b1);
        checkOutput("setwin_pending", int'(bus.pending), 'h10);
        checkOutput("setwin_gap", int'(bus.out_valid), 0);
        tick();
        checkOutput("setwin_reoffer", int'(bus.out_idx), 4);
        tick();
        applyStimulus(1'b1, 8'h00, 1'b0);
        checkOutput("setwin_idle", int'(bus.out_valid), 0);

        // All lines pending while disabled, then drained in index order.
        applyStimulus(1'b0, 8'hFF, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        tick(2);
        checkOutput("full_nooffer", int'(bus.out_valid), 0);
        checkOutput("full_pending", int'(bus.pending), 'hFF);
        checkOutput("full_any", int'(bus.any), 1);
        for (int i = 0; i < 8; i++) expQ.push_back(3'(i));
        applyStimulus(1'b1, 8'h00, 1'b1);
        tick(9);
        applyStimulus(1'b1, 8'h00, 1'b0);
        checkOutput("full_drained", int'(bus.pending), 'h00);
        checkOutput("full_idle", int'(bus.out_valid), 0);

        // Asynchronous reset in the middle of an offer.
        applyStimulus(1'b1, 8'h81, 1'b0);
        tick();
        applyStimulus(1'b1, 8'h00, 1'b0);
        tick();
        checkOutput("arst_pre_valid", int'(bus.out_valid), 1);
        checkOutput("arst_pre_pending", int'(bus.pending), 'h81);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", int'(bus.out_valid), 0);
        checkOutput("arst_pending", int'(bus.pending), 'h00);
        checkOutput("arst_any", int'(bus.any), 0);
        tick();
        rst_n = 1'b1;
        tick(2);
        checkOutput("arst_stays_idle", int'(bus.out_valid), 0);

        checkOutput("queue_drained", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
